// File: rtl/mnist_argmax.sv
`default_nettype none
// ============================================================================
//  Module      : mnist_argmax
//  Description : Classification back-end for the MNIST network. Accumulates
//                the final-layer logits of every class over all spatial
//                positions of a frame (saturating), then scans the
//                accumulators serially for the maximum and presents the
//                winning class index and score on a ready/valid output.
//  Revision    : 1.0 - initial release
// ============================================================================
module mnist_argmax #(
    parameter int N         = 8,
    parameter int NUM_CLASS = 10,
    parameter int PIXELS    = 1,
    parameter int ACC_W     = 16,
    parameter int IDX_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,       // active-high despite the name
    input  logic                   din_vld,
    input  logic [NUM_CLASS*N-1:0] din,
    input  logic                   din_end,
    output logic [IDX_W-1:0]       class_idx,
    output logic [ACC_W-1:0]       class_score,
    output logic                   class_vld,
    input  logic                   class_rdy,
    output logic                   busy,
    output logic                   overrun
);

    localparam int c_PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

    localparam logic [1:0] c_ST_ACCUM = 2'd0;
    localparam logic [1:0] c_ST_SCAN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(PIXELS - 1);
    localparam logic [IDX_W-1:0]   c_IDX_LAST = IDX_W'(NUM_CLASS - 1);
    localparam logic [ACC_W-1:0]   c_ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]   c_ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

    logic [1:0]         r_state;
    logic [c_PIX_W-1:0] r_pix_cnt;
    logic [IDX_W-1:0]   r_scan_idx;
    logic               r_scan_done;
    logic [ACC_W-1:0]   r_best_val;
    logic [IDX_W-1:0]   r_best_idx;
    logic [IDX_W-1:0]   r_class_idx;
    logic [ACC_W-1:0]   r_class_score;
    logic               r_class_vld;
    logic               r_busy;
    logic               r_overrun;

    logic [ACC_W-1:0]   w_acc [NUM_CLASS];
    logic               w_beat_take;
    logic               w_frame_end;
    logic               w_handshake;
    logic [ACC_W-1:0]   w_cur;
    logic               w_take;

    // A beat is only absorbed while accumulating; the frame closes on an
    // explicit end strobe or when the pixel counter reaches the last position.
    assign w_beat_take = (r_state == c_ST_ACCUM) && din_vld;
    assign w_frame_end = w_beat_take && (din_end || (r_pix_cnt == c_PIX_LAST));
    assign w_handshake = (r_state == c_ST_HOLD) && class_rdy;

    // Scan comparator: index 0 seeds the running best, later indices replace
    // it only when strictly greater, so ties keep the lowest index.
    assign w_cur  = w_acc[r_scan_idx];
    assign w_take = (r_scan_idx == '0) || ($signed(w_cur) > $signed(r_best_val));

    generate
        for (genvar c = 0; c < NUM_CLASS; c++) begin : g_class
            logic [ACC_W-1:0] r_acc;
            logic [ACC_W:0]   w_sum;
            logic [ACC_W-1:0] w_sat;

            // One guard bit catches overflow; differing top bits mean clamp.
            assign w_sum = {r_acc[ACC_W-1], r_acc}
                         + {{(ACC_W+1-N){din[c*N+N-1]}}, din[c*N +: N]};
            assign w_sat = (w_sum[ACC_W] != w_sum[ACC_W-1])
                         ? (w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX)
                         : w_sum[ACC_W-1:0];
            assign w_acc[c] = r_acc;

            // Per-class accumulator: add on accepted beats, clear once the
            // result has been consumed.
            always_ff @(posedge clk) begin
                if (rst_n) begin
                    r_acc <= '0;
                end else if (w_beat_take) begin
                    r_acc <= w_sat;
                end else if (w_handshake) begin
                    r_acc <= '0;
                end
            end
        end
    endgenerate

    // Control FSM: pixel counting, serial argmax scan, result hold/handshake.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state       <= c_ST_ACCUM;
            r_pix_cnt     <= '0;
            r_scan_idx    <= '0;
            r_scan_done   <= 1'b0;
            r_best_val    <= '0;
            r_best_idx    <= '0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_class_vld   <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_ACCUM: begin
                    if (w_frame_end) begin
                        r_pix_cnt   <= '0;
                        r_scan_idx  <= '0;
                        r_scan_done <= 1'b0;
                        r_state     <= c_ST_SCAN;
                        r_busy      <= 1'b1;
                    end else if (w_beat_take) begin
                        r_pix_cnt <= r_pix_cnt + 1'b1;
                    end
                end
                c_ST_SCAN: begin
                    if (din_vld) begin
                        r_overrun <= 1'b1;
                    end
                    if (!r_scan_done) begin
                        if (w_take) begin
                            r_best_val <= w_cur;
                            r_best_idx <= r_scan_idx;
                        end
                        if (r_scan_idx == c_IDX_LAST) begin
                            r_scan_done <= 1'b1;
                        end else begin
                            r_scan_idx <= r_scan_idx + 1'b1;
                        end
                    end else begin
                        // Every index has been compared; publish the winner.
                        r_class_idx   <= r_best_idx;
                        r_class_score <= r_best_val;
                        r_class_vld   <= 1'b1;
                        r_scan_idx    <= '0;
                        r_scan_done   <= 1'b0;
                        r_state       <= c_ST_HOLD;
                    end
                end
                c_ST_HOLD: begin
                    if (din_vld) begin
                        r_overrun <= 1'b1;
                    end
                    if (class_rdy) begin
                        r_class_vld <= 1'b0;
                        r_scan_idx  <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_ACCUM;
                    end
                end
                default: begin
                    r_state <= c_ST_ACCUM;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;
    assign class_vld   = r_class_vld;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
